mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit owning the HI/LO register pair for MIPS32 MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Sits beside the single-cycle ALU in EX; accepts one request via valid/ready and writes HI/LO at completion.
//  EX stalls on busy; MFHI/MFLO read hi/lo directly.
// PARAMETERS
//  DATA_W  32  operand and HI/LO width; only 32 is supported
// PORTS
//  clk        in   1       clock, rising edge
//  resetn     in   1       asynchronous, active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       unit can accept; = (state==IDLE) && !flush
//  op         in   3       000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  src1       in   DATA_W  rs: multiplicand/dividend; MTHI/MTLO data
//  src2       in   DATA_W  rt: multiplier/divisor
//  flush      in   1       pipeline flush; aborts any in-flight op
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse when HI/LO take a mul/div result
//  hi, lo     out  DATA_W  architectural HI/LO registers
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, hi=lo=0, done=0, busy=0, all datapath registers cleared.
//  Accept: rising edge E0 with req_valid && req_ready. Operands and op are latched at E0.
//  States: IDLE -> CALC (32 iterations) -> FIX -> IDLE.
//  - IDLE: a mul/div accept goes to CALC; MTHI/MTLO write hi/lo at E0 and stay IDLE (no busy, no done).
//    The no-op codes are accepted and ignored.
//  - CALC: radix-2, one bit per cycle on operand magnitudes (signed ops: abs values).
//    Multiply uses shift-add into a 64-bit accumulator; divide uses restoring shift-subtract.
//    CALC occupies edges E1..E32.
//  - FIX: at edge E33, apply the sign correction and write {hi,lo}; done=1 for the cycle after E33; return to IDLE.
//    Latency is 33 cycles from accept to done; hi/lo are stable from done onward.
//    req_ready goes high again in that same done cycle (back-to-back issue allowed).
//  Multiply: {hi,lo} = 64-bit product. MULT is signed x signed; MULTU is unsigned.
//  Divide: lo = quotient, hi = remainder, truncating toward zero. Quotient is negative iff operand signs differ.
//    The remainder takes the dividend's sign.
//  Boundaries:
//  - Divide by zero (src2==0): lo=32'hFFFFFFFF, hi=src1. Still takes the full 33 cycles.
//  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0. No trap.
//  - MULT 32'h80000000 * 32'h80000000: {hi,lo}=64'h4000_0000_0000_0000.
//  - flush in any state: next edge goes to IDLE, hi/lo unchanged, done stays 0.
//    flush in the FIX cycle suppresses the write.
//  - flush together with req_valid: req_ready=0, so the request is not accepted.
//  - req_valid while busy: ignored (req_ready=0). Inputs are not sampled after E0.
//  - resetn asserted mid-operation: immediate IDLE, hi=lo=0, done=0.
// CONFIGURATION
//  MDU_FAST_MUL_EN defined:
//  - MULT/MULTU compute a combinational 32x32 product at E0 and go IDLE -> FIX.
//  - FIX writes {hi,lo} at E1; done is high the cycle after E1, so latency is 1 cycle.
//  - Divide is unchanged (33 cycles).
//  MDU_FAST_MUL_EN undefined: all mul/div ops take 33 cycles as above; no 32x32 multiplier is instantiated.
// TESTING
//  1. MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> done 33 cycles after accept (1 with macro); hi=32'hFFFFFFFE, lo=32'h00000001.
//  2. DIV -7 / 2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU 7/2 -> lo=3, hi=1. Both 33 cycles.
//  3. DIV x / 0 with src1=32'h1234 -> lo=32'hFFFFFFFF, hi=32'h1234.
//     DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
//  4. MTHI 32'hA5A5A5A5 then MTLO 32'h5A5A5A5A on consecutive cycles -> hi/lo updated at each accept edge.
//     busy and done stay 0 throughout.
//  5. Start DIVU, pulse flush at cycle 10 -> busy falls next edge, hi/lo keep prior values, no done.
//     A new MULT accepted the following cycle completes correctly.
//  6. Deassert resetn at cycle 20 of a MULT -> hi=lo=0, busy=0, done=0 immediately.
//     After release, back-to-back MULT, DIV with req_valid held high -> two done pulses with correct results.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// -----------------------------------------------------------------------------
// mul_div_unit_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//
//   Signals
//     req_valid  request present (EX -> MDU)
//     req_ready  unit can accept this cycle (MDU -> EX)
//     op         3-bit operation code (MULT/MULTU/DIV/DIVU/MTHI/MTLO/no-op)
//     src1       rs operand: multiplicand / dividend / MTHI-MTLO data
//     src2       rt operand: multiplier / divisor
//     flush      pipeline flush, aborts any in-flight operation
//     busy       unit is working on a mul/div (EX stalls on this)
//     done       one-cycle pulse when HI/LO take a mul/div result
//     hi, lo     architectural HI/LO registers
//
//   Modports
//     master  EX stage / testbench side
//     slave   mul_div_unit side
// -----------------------------------------------------------------------------
interface mul_div_unit_if #(
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output req_valid, op, src1, src2, flush,
        input  req_ready, busy, done, hi, lo
    );

    modport slave (
        input  req_valid, op, src1, src2, flush,
        output req_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle multiply/divide unit owning the MIPS32 HI/LO register pair.
//   Handles MULT, MULTU, DIV, DIVU (radix-2, one bit per cycle on operand
//   magnitudes, sign fixed up at the end) and MTHI/MTLO (written at accept).
//   Op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//   11x no-op.
//
//   Ports
//     clk     rising-edge clock
//     resetn  asynchronous active-low reset
//     bus     mul_div_unit_if.slave (request handshake, flush, status, hi/lo)
//
//   Build option
//     MDU_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle 32x32
//                      product and skip the iterative phase (1-cycle latency).
//                      When undefined, every mul/div takes 33 cycles and no
//                      hardware multiplier is instantiated.
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          resetn,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement negate when n is set.
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                   input logic n);
        return n ? ({DATA_W{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v,
                                                      input logic n);
        return n ? ({(2*DATA_W){1'b0}} - v) : v;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*DATA_W-1:0] acc_q, acc_d;
    // Multiplicand magnitude (mul) or divisor magnitude (div).
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;      // negate product / quotient
    logic                rneg_q, rneg_d;    // negate remainder (dividend sign)
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic                accept;
    logic                is_signed;
    logic                src1_neg, src2_neg;
    logic [DATA_W-1:0]   mag1, mag2;
    logic [DATA_W:0]     add_sum;
    logic [2*DATA_W-1:0] mul_step;
    logic [DATA_W:0]     rem_sh;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_sub;
    logic [2*DATA_W-1:0] div_step;
    logic [2*DATA_W-1:0] mul_res;
    logic [DATA_W-1:0]   quo_res, rem_res;

    assign bus.req_ready = (state_q == S_IDLE) && !bus.flush;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    assign accept    = bus.req_valid && bus.req_ready;
    // op[0] distinguishes the unsigned variants of mul/div.
    assign is_signed = !bus.op[0];
    assign src1_neg  = is_signed && bus.src1[DATA_W-1];
    assign src2_neg  = is_signed && bus.src2[DATA_W-1];
    assign mag1      = cond_neg(bus.src1, src1_neg);
    assign mag2      = cond_neg(bus.src2, src2_neg);

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign add_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    assign mul_step = acc_q[0] ? {add_sum, acc_q[DATA_W-1:1]} : {1'b0, acc_q[2*DATA_W-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and
    // subtract the divisor when it fits. The shifted remainder is always
    // below twice the divisor, so the difference fits in DATA_W bits.
    // A zero divisor always "fits", giving an all-ones quotient and the
    // dividend magnitude as remainder.
    assign rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    assign rem_sub  = rem_sh[DATA_W-1:0] - opnd_q;
    assign div_step = rem_ge ? {rem_sub, acc_q[DATA_W-2:0], 1'b1}
                             : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

    assign mul_res = cond_neg2(acc_q, neg_q);
    assign quo_res = div0_q ? {DATA_W{1'b1}} : cond_neg(acc_q[DATA_W-1:0], neg_q);
    assign rem_res = cond_neg(acc_q[2*DATA_W-1:DATA_W], rneg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        3'b000, 3'b001: begin
                            is_div_d = 1'b0;
                            neg_d    = src1_neg ^ src2_neg;
                            rneg_d   = 1'b0;
                            div0_d   = 1'b0;
                            opnd_d   = mag1;
                            cnt_d    = '0;
`ifdef MDU_FAST_MUL_EN
                            acc_d    = {{DATA_W{1'b0}}, mag1} * {{DATA_W{1'b0}}, mag2};
                            state_d  = S_FIX;
`else
                            acc_d    = {{DATA_W{1'b0}}, mag2};
                            state_d  = S_CALC;
`endif
                        end
                        3'b010, 3'b011: begin
                            is_div_d = 1'b1;
                            neg_d    = src1_neg ^ src2_neg;
                            rneg_d   = src1_neg;
                            div0_d   = (bus.src2 == {DATA_W{1'b0}});
                            opnd_d   = mag2;
                            acc_d    = {{DATA_W{1'b0}}, mag1};
                            cnt_d    = '0;
                            state_d  = S_CALC;
                        end
                        3'b100:  hi_d = bus.src1;
                        3'b101:  lo_d = bus.src1;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = is_div_q ? rem_res : mul_res[2*DATA_W-1:DATA_W];
                lo_d    = is_div_q ? quo_res : mul_res[DATA_W-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush aborts whatever is in flight and blocks the HI/LO write.
        if (bus.flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end
endmodule
